// File: rtl/ctrl_pkg.sv
// Shared types for the instruction controller: opcodes, FSM states, ALU selects,
// field widths and the per-state output decode.
package ctrl_pkg;

    localparam int OPC_W   = 3;
    localparam int RD_W    = 4;
    localparam int INSTR_W = OPC_W + RD_W;
    localparam int STATE_W = 4;
    localparam int DADDR_W = 8;
    localparam int CNT_W   = 16;

    typedef enum logic [OPC_W-1:0] {
        OP_NOOP  = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_HALT  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } opcode_e;

    typedef enum logic [STATE_W-1:0] {
        S_INIT   = 4'd0,
        S_PRIME  = 4'd1,
        S_FETCH  = 4'd2,
        S_DECODE = 4'd3,
        S_NOOP   = 4'd4,
        S_LOAD_A = 4'd5,
        S_LOAD_B = 4'd6,
        S_STORE  = 4'd7,
        S_ADD    = 4'd8,
        S_SUB    = 4'd9,
        S_HALT   = 4'd10
    } state_e;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    typedef struct packed {
        logic               pc_clr;
        logic               pc_up;
        logic [DADDR_W-1:0] d_addr;
        logic               d_wr;
        logic               rf_s;
        logic               rf_w_en;
        logic [RD_W-1:0]    rf_w_addr;
        logic [RD_W-1:0]    rf_ra_addr;
        logic [RD_W-1:0]    rf_rb_addr;
        logic [2:0]         alu_s;
        logic               halted;
    } ctrl_out_t;

    // Moore output decode; everything not named for a state stays low.
    function automatic ctrl_out_t ctrl_outputs(input state_e st,
                                               input logic [RD_W-1:0] rd,
                                               input logic [RD_W-1:0] acc);
        ctrl_out_t o;
        o        = '0;
        o.d_addr = {{(DADDR_W-RD_W){1'b0}}, rd};
        case (st)
            S_INIT:   o.pc_clr = 1'b1;
            S_FETCH:  o.pc_up  = 1'b1;
            S_LOAD_B: begin
                o.rf_s      = 1'b1;
                o.rf_w_en   = 1'b1;
                o.rf_w_addr = rd;
            end
            S_STORE: begin
                o.d_wr       = 1'b1;
                o.rf_ra_addr = rd;
            end
            S_ADD, S_SUB: begin
                o.rf_ra_addr = acc;
                o.rf_rb_addr = rd;
                o.alu_s      = (st == S_ADD) ? ALU_ADD : ALU_SUB;
                o.rf_w_en    = 1'b1;
                o.rf_w_addr  = acc;
            end
            S_HALT:   o.halted = 1'b1;
            default:  o.pc_clr = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/instr_ctrl_decode.sv
// Combinational instruction decoder: splits IR into opcode class and Rd and
// flags the reserved opcodes 6/7, which execute as NOOP.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0] ir_i,
    output opcode_e            op_o,
    output logic [RD_W-1:0]    rd_o,
    output logic               illegal_o
);

    always_comb begin
        op_o      = OP_NOOP;
        illegal_o = 1'b0;
        rd_o      = ir_i[RD_W-1:0];
        case (opcode_e'(ir_i[INSTR_W-1:RD_W]))
            OP_RSV6, OP_RSV7: begin
                op_o      = OP_NOOP;
                illegal_o = 1'b1;
            end
            default: op_o = opcode_e'(ir_i[INSTR_W-1:RD_W]);
        endcase
    end

endmodule

// File: rtl/instr_ctrl.sv
// Multi-cycle instruction controller (INIT/PRIME/FETCH/DECODE/execute/HALT).
// Optional retired-instruction counter enabled by macro CTRL_RETIRE_CNT_EN.
module instr_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [3:0] ACC_ADDR = 4'd0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [6:0]   Instr,
    output logic         PC_Clr,
    output logic         PC_Up,
    output logic [7:0]   D_Addr,
    output logic         D_Wr,
    output logic         RF_s,
    output logic         RF_W_en,
    output logic [3:0]   RF_W_addr,
    output logic [3:0]   RF_Ra_addr,
    output logic [3:0]   RF_Rb_addr,
    output logic [2:0]   ALU_s,
    output logic         Halted,
    output logic         Illegal,
    output logic [15:0]  RetCnt,
    output logic [3:0]   State
);

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 illegal_q, illegal_d;
    ctrl_out_t            out_q, out_d;
    opcode_e              dec_op;
    logic [RD_W-1:0]      dec_rd;
    logic                 dec_illegal;

    // Decoding ir_d lets outputs be registered against the state being entered;
    // ir_d only differs from ir_q on the FETCH edge, when IR itself loads.
    instr_decode u_decode (
        .ir_i      (ir_d),
        .op_o      (dec_op),
        .rd_o      (dec_rd),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            S_INIT:   state_d = S_PRIME;
            S_PRIME:  state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = Instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (dec_op)
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_STORE: state_d = S_STORE;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_NOOP;
                endcase
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                end else begin
                    illegal_d = illegal_q;
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
        out_d = ctrl_outputs(state_d, dec_rd, ACC_ADDR);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_INIT;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            out_q     <= ctrl_outputs(S_INIT, {RD_W{1'b0}}, ACC_ADDR);
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            out_q     <= out_d;
        end
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] retcnt_q, retcnt_d;
    logic             retire_s;

    // An instruction retires when an execute state hands back to FETCH.
    always_comb begin
        retire_s = 1'b0;
        case (state_q)
            S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: retire_s = (state_d == S_FETCH);
            default: retire_s = 1'b0;
        endcase
        if (retire_s && (retcnt_q != {CNT_W{1'b1}})) begin
            retcnt_d = retcnt_q + 16'd1;
        end else begin
            retcnt_d = retcnt_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            retcnt_q <= 16'h0000;
        end else begin
            retcnt_q <= retcnt_d;
        end
    end

    assign RetCnt = retcnt_q;
`else
    assign RetCnt = 16'h0000;
`endif

    assign PC_Clr     = out_q.pc_clr;
    assign PC_Up      = out_q.pc_up;
    assign D_Addr     = out_q.d_addr;
    assign D_Wr       = out_q.d_wr;
    assign RF_s       = out_q.rf_s;
    assign RF_W_en    = out_q.rf_w_en;
    assign RF_W_addr  = out_q.rf_w_addr;
    assign RF_Ra_addr = out_q.rf_ra_addr;
    assign RF_Rb_addr = out_q.rf_rb_addr;
    assign ALU_s      = out_q.alu_s;
    assign Halted     = out_q.halted;
    assign Illegal    = illegal_q;
    assign State      = state_q;

endmodule

// File: doc/instr_ctrl.md
INSTR_CTRL -- requirements
Module: instr_ctrl

Interface
REQ-001 Parameter ACC_ADDR, default 4'd0: register-file index used as accumulator by ADD/SUB.
REQ-002 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Instr  in  7  registered instruction-ROM output; [6:4]=opcode, [3:0]=Rd.
REQ-005 PC_Clr  out  1  clears upstream fetch address to 0.
REQ-006 PC_Up  out  1  advances upstream fetch address by 1; wraps 127->0 upstream.
REQ-007 D_Addr  out  8  data-memory address, {4'h0, IR[3:0]}.
REQ-008 D_Wr  out  1  data-memory write strobe.
REQ-009 RF_s  out  1  register-file write-data select: 1=data memory, 0=ALU.
REQ-010 RF_W_en / RF_W_addr  out  1 / 4  register-file write enable and address.
REQ-011 RF_Ra_addr / RF_Rb_addr  out  4 / 4  register-file read addresses.
REQ-012 ALU_s  out  3  ALU op: 0=pass A, 1=A+B, 2=A-B.
REQ-013 Halted  out  1  high while in HALT.
REQ-014 Illegal  out  1  sticky; set on opcode 6 or 7.
REQ-015 RetCnt  out  16  retired-instruction count.
REQ-016 State  out  4  current state encoding, for debug.

Function
REQ-017 Opcodes: 0 NOOP, 1 LOAD (RF[Rd]<=D[Rd]), 2 STORE (D[Rd]<=RF[Rd]), 3 ADD (RF[ACC]<=RF[ACC]+RF[Rd]), 4 SUB (RF[ACC]<=RF[ACC]-RF[Rd]), 5 HALT.
REQ-018 States: INIT, PRIME, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
REQ-019 INIT: PC_Clr=1 -> PRIME; PRIME: all strobes 0 (ROM latency) -> FETCH.
REQ-020 FETCH: IR loads Instr at the clock edge, PC_Up=1 for exactly this cycle -> DECODE.
REQ-021 DECODE: strobes 0; next state selected by IR[6:4]; opcodes 6/7 -> NOOP and set Illegal.
REQ-022 LOAD_A: D_Addr valid -> LOAD_B; LOAD_B: RF_s=1, RF_W_en=1, RF_W_addr=Rd -> FETCH.
REQ-023 STORE: D_Wr=1, RF_Ra_addr=Rd, D_Addr valid, one cycle -> FETCH.
REQ-024 ADD/SUB: RF_Ra_addr=ACC_ADDR, RF_Rb_addr=Rd, ALU_s=1/2, RF_s=0, RF_W_en=1, RF_W_addr=ACC_ADDR, one cycle -> FETCH; arithmetic modulo 2^16 in datapath.
REQ-025 NOOP: no strobes -> FETCH.
REQ-026 HALT: all strobes 0, Halted=1; stays until Reset.
REQ-027 Cycle counts: NOOP/STORE/ADD/SUB 3 cycles, LOAD 4, from FETCH to next FETCH.
REQ-028 D_Addr and RF addresses derive from IR only, never from live Instr.
REQ-029 Instr stable through FETCH is guaranteed by at least two cycles between PC_Up and the next FETCH.

Reset
REQ-030 Reset forces INIT, IR=0, Illegal=0, RetCnt=0 at the next edge, from any state including mid-LOAD and HALT.
REQ-031 During and one cycle after Reset: PC_Clr=1 (INIT), all other strobes 0, Halted=0.

Configuration
REQ-032 Macro CTRL_RETIRE_CNT_EN defined: RetCnt increments by 1 on each transition into FETCH from an execute state, saturating at 16'hFFFF.
REQ-033 Macro absent: RetCnt tied to 16'h0000, no counter logic.

Structure
REQ-034 ctrl_pkg holds opcode enum, state enum, ALU_s constants, and instruction field widths.
REQ-035 Sub-module instr_decode: combinational; IR -> opcode class, Rd, illegal flag.

Verification
REQ-036 Reset held 3 cycles, then released -> INIT (PC_Clr=1), PRIME, FETCH with PC_Up=1 exactly one cycle.
REQ-037 Instr=7'b011_0011 (ADD R3) -> ALU_s=1, RF_Rb_addr=3, RF_W_addr=0, RF_W_en=1 in cycle 3.
REQ-038 Instr=7'b001_0101 (LOAD R5) -> D_Addr=8'h05 in LOAD_A; RF_s=1, RF_W_en=1, RF_W_addr=5 in LOAD_B; 4 cycles total.
REQ-039 Instr=7'b111_0000 -> Illegal=1 and stays 1 across later legal instructions; no write strobes.
REQ-040 Instr=7'b101_0000 (HALT) -> Halted=1, PC_Up=0 for 20 cycles; Reset -> INIT next edge.
REQ-041 With CTRL_RETIRE_CNT_EN: 10 NOOPs -> RetCnt=10; Reset asserted during LOAD_B -> RetCnt=0, RF_W_en=0.
